// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: credit-limited request issue toward instruction
// memory, in-order response capture into a prefetch queue, and redirect flush.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  output logic [31:0] Inst_Addr,
  input  logic        Inst_Resp_Valid,
  output logic        Inst_Resp_Ready,
  input  logic [31:0] Instruction,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_PC,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_PC,
  output logic [31:0] Out_Instruction
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   q_pc_q   [FIFO_DEPTH];
  logic [31:0]   q_pc_d   [FIFO_DEPTH];
  logic [31:0]   q_inst_q [FIFO_DEPTH];
  logic [31:0]   q_inst_d [FIFO_DEPTH];

  logic          req_fire;
  logic          resp_acc;
  logic          push;
  logic          pop;
  logic [SW-1:0] occupancy;

  // In-flight requests reserve a queue slot, so an accepted response always fits.
  assign occupancy       = SW'(outstanding_q) + SW'(count_q);
  assign Inst_Req_Valid  = rst & ~Redirect_Valid
                         & (outstanding_q < OW'(MAX_OUTSTANDING))
                         & (occupancy < SW'(FIFO_DEPTH));
  assign Inst_Addr       = fetch_pc_q;
  assign Inst_Resp_Ready = 1'b1;
  assign req_fire        = Inst_Req_Valid & Inst_Req_Ready;
  assign resp_acc        = Inst_Resp_Valid;
  assign push            = resp_acc & (discard_q == '0) & ~Redirect_Valid;
  assign Out_Valid       = rst & (count_q != '0);
  assign pop             = Out_Valid & Out_Ready;
  assign Out_PC          = q_pc_q[rd_ptr_q];
  assign Out_Instruction = q_inst_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    q_pc_d        = q_pc_q;
    q_inst_d      = q_inst_q;

    if (Redirect_Valid) begin
      // Every request still unanswered after this cycle is stale.
      fetch_pc_d    = {Redirect_PC[31:2], 2'b00};
      resp_pc_d     = {Redirect_PC[31:2], 2'b00};
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = outstanding_q - OW'(Inst_Resp_Valid);
      discard_d     = outstanding_q - OW'(Inst_Resp_Valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      case ({req_fire, resp_acc})
        2'b10:   outstanding_d = outstanding_q + OW'(1);
        2'b01:   outstanding_d = outstanding_q - OW'(1);
        default: outstanding_d = outstanding_q;
      endcase
      if (resp_acc && (discard_q != '0)) begin
        discard_d = discard_q - OW'(1);
      end
      if (push) begin
        q_pc_d[wr_ptr_q]   = resp_pc_q;
        q_inst_d[wr_ptr_q] = Instruction;
        wr_ptr_d           = wr_ptr_q + AW'(1);
        resp_pc_d          = resp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    q_pc_q   <= q_pc_d;
    q_inst_q <= q_inst_d;
  end

  a_count_max: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CW'(FIFO_DEPTH));
  a_outstanding_max: assert property (@(posedge clk) disable iff (!rst)
    outstanding_q <= OW'(MAX_OUTSTANDING));
  a_discard_le_out: assert property (@(posedge clk) disable iff (!rst)
    discard_q <= outstanding_q);
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
    !(Inst_Resp_Valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed cycle vectors for mips_fetch_unit, a long back-pressure run against a
// one-cycle memory, and a PC wrap check on a second instance.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, rv, redir, ordy;
  logic [31:0] inst, rpc;
  logic        req_v, resp_r, out_v;
  logic [31:0] addr, out_pc, out_inst;

  logic        w_rst, w_rdy, w_rv, w_redir, w_ordy;
  logic [31:0] w_inst, w_rpc;
  logic        w_req_v, w_resp_r, w_out_v;
  logic [31:0] w_addr, w_out_pc, w_out_inst;

  mips_fetch_unit dut (
    .clk(clk), .rst(rst),
    .Inst_Req_Valid(req_v), .Inst_Req_Ready(rdy), .Inst_Addr(addr),
    .Inst_Resp_Valid(rv), .Inst_Resp_Ready(resp_r), .Instruction(inst),
    .Redirect_Valid(redir), .Redirect_PC(rpc),
    .Out_Valid(out_v), .Out_Ready(ordy), .Out_PC(out_pc), .Out_Instruction(out_inst)
  );

  mips_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut_w (
    .clk(clk), .rst(w_rst),
    .Inst_Req_Valid(w_req_v), .Inst_Req_Ready(w_rdy), .Inst_Addr(w_addr),
    .Inst_Resp_Valid(w_rv), .Inst_Resp_Ready(w_resp_r), .Instruction(w_inst),
    .Redirect_Valid(w_redir), .Redirect_PC(w_rpc),
    .Out_Valid(w_out_v), .Out_Ready(w_ordy), .Out_PC(w_out_pc), .Out_Instruction(w_out_inst)
  );

  // ctrl = {rst, req_ready, resp_valid, redirect, out_ready}; exp = {req_valid, out_valid}
  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] inst;
    logic [31:0] rpc;
    logic [1:0]  exp;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[$];
  vec_t wtbl[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic [4:0] c, input logic [31:0] i, input logic [31:0] r,
                              input logic [1:0] e, input logic [31:0] a,
                              input logic [31:0] p, input logic [31:0] n);
    vec_t v;
    v.ctrl = c; v.inst = i; v.rpc = r; v.exp = e; v.addr = a; v.pc = p; v.ins = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit w, input int idx);
    logic        a_req, a_ov;
    logic [31:0] a_addr, a_pc, a_ins;
    string       tag;
    @(negedge clk);
    if (!w) begin
      {rst, rdy, rv, redir, ordy} = v.ctrl;
      inst = v.inst; rpc = v.rpc;
    end else begin
      {w_rst, w_rdy, w_rv, w_redir, w_ordy} = v.ctrl;
      w_inst = v.inst; w_rpc = v.rpc;
    end
    #1;
    if (!w) begin
      a_req = req_v; a_addr = addr; a_ov = out_v; a_pc = out_pc; a_ins = out_inst;
    end else begin
      a_req = w_req_v; a_addr = w_addr; a_ov = w_out_v; a_pc = w_out_pc; a_ins = w_out_inst;
    end
    tag = $sformatf("%s%0d", w ? "w" : "v", idx);
    check({tag, " req_valid"}, {31'd0, a_req}, {31'd0, v.exp[1]});
    check({tag, " inst_addr"}, a_addr, v.addr);
    check({tag, " out_valid"}, {31'd0, a_ov}, {31'd0, v.exp[0]});
    if (v.exp[0]) begin
      check({tag, " out_pc"}, a_pc, v.pc);
      check({tag, " out_inst"}, a_ins, v.ins);
    end
  endtask

  initial begin
    logic        fired;
    logic [31:0] last_addr;

    // Main instance: reset, streaming, stall, redirects, mid-stream reset.
    tbl.push_back(mk(5'b01001, 32'h0, 32'h0, 2'b00, 32'h00000000, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11001, 32'h0, 32'h0, 2'b10, 32'h00000000, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11101, 32'h10000000, 32'h0, 2'b10, 32'h00000004, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11101, 32'h10000004, 32'h0, 2'b11, 32'h00000008, 32'h00000000, 32'h10000000));
    tbl.push_back(mk(5'b11101, 32'h10000008, 32'h0, 2'b11, 32'h0000000C, 32'h00000004, 32'h10000004));
    tbl.push_back(mk(5'b11101, 32'h1000000C, 32'h0, 2'b11, 32'h00000010, 32'h00000008, 32'h10000008));
    tbl.push_back(mk(5'b11100, 32'h10000010, 32'h0, 2'b11, 32'h00000014, 32'h0000000C, 32'h1000000C));
    tbl.push_back(mk(5'b11100, 32'h10000014, 32'h0, 2'b11, 32'h00000018, 32'h0000000C, 32'h1000000C));
    tbl.push_back(mk(5'b11100, 32'h10000018, 32'h0, 2'b01, 32'h0000001C, 32'h0000000C, 32'h1000000C));
    tbl.push_back(mk(5'b11000, 32'h0, 32'h0, 2'b01, 32'h0000001C, 32'h0000000C, 32'h1000000C));
    tbl.push_back(mk(5'b11000, 32'h0, 32'h0, 2'b01, 32'h0000001C, 32'h0000000C, 32'h1000000C));
    tbl.push_back(mk(5'b11001, 32'h0, 32'h0, 2'b01, 32'h0000001C, 32'h0000000C, 32'h1000000C));
    tbl.push_back(mk(5'b11001, 32'h0, 32'h0, 2'b11, 32'h0000001C, 32'h00000010, 32'h10000010));
    tbl.push_back(mk(5'b11101, 32'h1000001C, 32'h0, 2'b11, 32'h00000020, 32'h00000014, 32'h10000014));
    tbl.push_back(mk(5'b11001, 32'h0, 32'h0, 2'b11, 32'h00000024, 32'h00000018, 32'h10000018));
    tbl.push_back(mk(5'b11111, 32'h10000020, 32'h00400103, 2'b01, 32'h00000028, 32'h0000001C, 32'h1000001C));
    tbl.push_back(mk(5'b11101, 32'h10000024, 32'h0, 2'b10, 32'h00400100, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11101, 32'h10400100, 32'h0, 2'b10, 32'h00400104, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11101, 32'h10400104, 32'h0, 2'b11, 32'h00400108, 32'h00400100, 32'h10400100));
    tbl.push_back(mk(5'b11000, 32'h0, 32'h0, 2'b11, 32'h0040010C, 32'h00400104, 32'h10400104));
    tbl.push_back(mk(5'b01000, 32'h0, 32'h0, 2'b00, 32'h00400110, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11001, 32'h0, 32'h0, 2'b10, 32'h00000000, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11101, 32'h10000000, 32'h0, 2'b10, 32'h00000004, 32'h0, 32'h0));
    tbl.push_back(mk(5'b10101, 32'h10000004, 32'h0, 2'b11, 32'h00000008, 32'h00000000, 32'h10000000));
    tbl.push_back(mk(5'b10001, 32'h0, 32'h0, 2'b11, 32'h00000008, 32'h00000004, 32'h10000004));
    tbl.push_back(mk(5'b10001, 32'h0, 32'h0, 2'b10, 32'h00000008, 32'h0, 32'h0));
    tbl.push_back(mk(5'b10011, 32'h0, 32'h00000203, 2'b00, 32'h00000008, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11011, 32'h0, 32'h00001000, 2'b00, 32'h00000200, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11001, 32'h0, 32'h0, 2'b10, 32'h00001000, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11101, 32'h10001000, 32'h0, 2'b10, 32'h00001004, 32'h0, 32'h0));
    tbl.push_back(mk(5'b10001, 32'h0, 32'h0, 2'b11, 32'h00001008, 32'h00001000, 32'h10001000));
    tbl.push_back(mk(5'b11001, 32'h0, 32'h0, 2'b10, 32'h00001008, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11011, 32'h0, 32'h00400103, 2'b00, 32'h0000100C, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11101, 32'h10001004, 32'h0, 2'b00, 32'h00400100, 32'h0, 32'h0));
    tbl.push_back(mk(5'b11101, 32'h10001008, 32'h0, 2'b10, 32'h00400100, 32'h0, 32'h0));
    tbl.push_back(mk(5'b10101, 32'h10400100, 32'h0, 2'b10, 32'h00400104, 32'h0, 32'h0));
    tbl.push_back(mk(5'b10001, 32'h0, 32'h0, 2'b11, 32'h00400104, 32'h00400100, 32'h10400100));
    tbl.push_back(mk(5'b10001, 32'h0, 32'h0, 2'b10, 32'h00400104, 32'h0, 32'h0));

    // Wrap instance: RESET_PC = 0xFFFFFFF8, word returned = ~address.
    wtbl.push_back(mk(5'b01001, 32'h0, 32'h0, 2'b00, 32'hFFFFFFF8, 32'h0, 32'h0));
    wtbl.push_back(mk(5'b11001, 32'h0, 32'h0, 2'b10, 32'hFFFFFFF8, 32'h0, 32'h0));
    wtbl.push_back(mk(5'b11101, 32'h00000007, 32'h0, 2'b10, 32'hFFFFFFFC, 32'h0, 32'h0));
    wtbl.push_back(mk(5'b11101, 32'h00000003, 32'h0, 2'b11, 32'h00000000, 32'hFFFFFFF8, 32'h00000007));
    wtbl.push_back(mk(5'b11101, 32'hFFFFFFFF, 32'h0, 2'b11, 32'h00000004, 32'hFFFFFFFC, 32'h00000003));
    wtbl.push_back(mk(5'b10101, 32'hFFFFFFFB, 32'h0, 2'b11, 32'h00000008, 32'h00000000, 32'hFFFFFFFF));
    wtbl.push_back(mk(5'b10001, 32'h0, 32'h0, 2'b11, 32'h00000008, 32'h00000004, 32'hFFFFFFFB));

    rst = 1'b0; rdy = 1'b0; rv = 1'b0; redir = 1'b0; ordy = 1'b0; inst = '0; rpc = '0;
    w_rst = 1'b0; w_rdy = 1'b0; w_rv = 1'b0; w_redir = 1'b0; w_ordy = 1'b0; w_inst = '0; w_rpc = '0;
    repeat (2) @(negedge clk);
    check("resp_ready_tied", {31'd0, resp_r}, 32'd1);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0, i);

    // Long back-pressure against a one-cycle memory, then drain in order.
    @(negedge clk);
    rst = 1'b0; rv = 1'b0; redir = 1'b0; ordy = 1'b0; rdy = 1'b1;
    fired = 1'b0; last_addr = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst = 1'b1; rdy = 1'b1; ordy = 1'b0;
      rv = fired; inst = 32'h10000000 | last_addr;
      #1;
      check($sformatf("stall%0d req_valid", i), {31'd0, req_v}, {31'd0, (i < 4)});
      check($sformatf("stall%0d out_valid", i), {31'd0, out_v}, {31'd0, (i >= 2)});
      if (i >= 2) check($sformatf("stall%0d out_pc", i), out_pc, 32'h0);
      fired = req_v & rdy; last_addr = addr;
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      ordy = 1'b1; rv = fired; inst = 32'h10000000 | last_addr;
      #1;
      check($sformatf("drain%0d out_valid", j), {31'd0, out_v}, 32'd1);
      check($sformatf("drain%0d out_pc", j), out_pc, 32'(4 * j));
      check($sformatf("drain%0d out_inst", j), out_inst, 32'h10000000 | 32'(4 * j));
      fired = req_v & rdy; last_addr = addr;
    end

    for (int i = 0; i < wtbl.size(); i++) apply(wtbl[i], 1'b1, i);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation MIPS core.
- Replaces the single-cycle "PC register plus combinational Instruction input" arrangement with a handshaked, latency-tolerant instruction-memory interface.
- Adds a prefetch queue and multiple outstanding requests.
- Supports redirect (branch/jump/jr target) with flush of queued and in-flight instructions.
- Sits between instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h00000000, fetch address loaded on reset.
- FIFO_DEPTH, 4, prefetch queue entries; power of 2, minimum 2.
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered memory requests; 1 to FIFO_DEPTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- Inst_Req_Valid  out  1  fetch request valid.
- Inst_Req_Ready  in  1  memory accepts request.
- Inst_Addr  out  32  fetch address, word-aligned.
- Inst_Resp_Valid  in  1  memory returns one instruction; responses arrive in request order.
- Inst_Resp_Ready  out  1  tied 1; unit always accepts responses.
- Instruction  in  32  returned instruction word.
- Redirect_Valid  in  1  one-cycle pulse: restart fetch at Redirect_PC.
- Redirect_PC  in  32  new fetch address; bits [1:0] ignored and forced 0.
- Out_Valid  out  1  queue head valid toward decode.
- Out_Ready  in  1  decode consumes head.
- Out_PC  out  32  PC of head instruction.
- Out_Instruction  out  32  head instruction word.

Behaviour:
- Reset (rst==0 at posedge):
  - fetch_pc=RESET_PC; resp_pc=RESET_PC.
  - Queue count, outstanding and discard counters cleared to 0.
  - Out_Valid=0 and Inst_Req_Valid=0 while rst==0.
  - Reset mid-operation abandons all in-flight requests. The memory model is reset by the same rst.
- Request issue:
  - Inst_Req_Valid = rst & ~Redirect_Valid & (outstanding < MAX_OUTSTANDING) & (outstanding + count < FIFO_DEPTH).
  - The credit rule guarantees every accepted response has a queue slot.
  - Inst_Addr = fetch_pc.
  - Fire = Inst_Req_Valid & Inst_Req_Ready: fetch_pc += 4 and outstanding += 1.
  - A Redirect_Valid cycle may withdraw a pending request; the memory treats an unfired request as never issued.
- Response:
  - Each accepted response decrements outstanding.
  - If discard > 0: drop the word and decrement discard.
  - Otherwise: push {resp_pc, Instruction} into the queue and resp_pc += 4.
  - Fire and response in the same cycle leave outstanding unchanged.
- Output:
  - Out_Valid = (count != 0); head fields come directly from the queue registers.
  - Pop on Out_Valid & Out_Ready.
  - Push and pop in the same cycle keep count unchanged, including at count==FIFO_DEPTH.
  - Earliest Out_Valid is the cycle after a response is accepted (1-cycle registered latency).
  - Out_PC and Out_Instruction hold stable while Out_Valid & ~Out_Ready.
- Redirect (Redirect_Valid==1):
  - Next state: fetch_pc = resp_pc = {Redirect_PC[31:2],2'b00}; count=0.
  - discard = outstanding - Inst_Resp_Valid, i.e. every in-flight request becomes stale.
  - A response arriving in the redirect cycle is dropped.
  - A pop in the redirect cycle completes: decode took that word; the remaining entries are flushed.
  - Back-to-back redirects: the last one wins; discard is recomputed each time.
  - Redirect has priority over all other updates except reset.
- Arithmetic and widths:
  - PC increments wrap modulo 2^32 (32'hFFFFFFFC + 4 = 0).
  - Counters are sized clog2(FIFO_DEPTH+1) and clog2(MAX_OUTSTANDING+1); they never overflow or underflow under legal stimulus.
- Assertions (verification):
  - count <= FIFO_DEPTH.
  - outstanding <= MAX_OUTSTANDING.
  - discard <= outstanding.
  - No response accepted while outstanding==0.

Test Plan:
- Reset, then zero-latency memory (Ready=1, response next cycle), Out_Ready=1 -> Out_PC sequence 0x0,0x4,0x8..., matching words; steady state of one instruction per cycle after initial fill.
- Out_Ready=0 for 20 cycles with default params -> count stalls at 4, Inst_Req_Valid drops once outstanding+count==4; Out_PC holds 0x0; releasing Out_Ready drains 0x0..0xC in order with no loss or duplicate.
- Memory latency 3 cycles, 2 requests in flight, pulse Redirect_Valid with Redirect_PC=0x00400103 -> both stale responses dropped; next Out_PC=0x00400100 with the instruction at that address; queue empty in the cycle after redirect.
- Redirect in the same cycle as a pop and a response arrival -> popped word counts as consumed; the arriving response is dropped; discard=outstanding-1; no stale PC ever appears on Out_PC.
- RESET_PC=32'hFFFFFFF8 -> Out_PC 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
- Assert rst=0 for one cycle mid-stream with 2 outstanding -> next cycle Out_Valid=0; fetch resumes at RESET_PC with counters 0.
